// File: rtl/astar_open_pq.sv
// Sorted priority queue for the A* open list: minimum-key entry always at e[0], FIFO among equal keys.
// Optional decrease-key deduplication on payload is enabled by defining SORT_DEDUP_EN.
module astar_open_pq #(
    parameter int KEY_W  = 16,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              push_valid_i,
    input  logic [KEY_W-1:0]  push_key_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic              push_ready_o,
    input  logic              pop_i,
    output logic              head_valid_o,
    output logic [KEY_W-1:0]  head_key_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              dropped_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [KEY_W-1:0]  key_q  [DEPTH];
    logic [KEY_W-1:0]  key_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              popFire, pushFire, isDup, drop, doIns;

    assign popFire  = pop_i & valid_q[0];
    assign pushFire = push_valid_i & (count_q != FULL_CNT);

    // Three stages on the stored image: pop shift-down, duplicate removal, then sorted insert.
    always_comb begin
        logic [KEY_W-1:0]  k1 [DEPTH];
        logic [DATA_W-1:0] d1 [DEPTH];
        logic [DEPTH-1:0]  v1;
        logic [KEY_W-1:0]  k2 [DEPTH];
        logic [DATA_W-1:0] d2 [DEPTH];
        logic [DEPTH-1:0]  v2;
        logic [DEPTH-1:0]  rm1;
        logic [DEPTH-1:0]  ge;
        logic [KEY_W-1:0]  mkey;
        logic              hit;

        for (int j = 0; j < DEPTH - 1; j++) begin
            k1[j] = popFire ? key_q[j+1]   : key_q[j];
            d1[j] = popFire ? data_q[j+1]  : data_q[j];
            v1[j] = popFire ? valid_q[j+1] : valid_q[j];
        end
        k1[DEPTH-1] = popFire ? '0   : key_q[DEPTH-1];
        d1[DEPTH-1] = popFire ? '0   : data_q[DEPTH-1];
        v1[DEPTH-1] = popFire ? 1'b0 : valid_q[DEPTH-1];

        rm1  = '0;
        mkey = '0;
        hit  = 1'b0;
        isDup = 1'b0;
        drop  = 1'b0;
`ifdef SORT_DEDUP_EN
        for (int j = 0; j < DEPTH; j++) begin
            if (v1[j] && (d1[j] == push_data_i) && !hit) begin
                mkey = k1[j];
                hit  = 1'b1;
            end
            rm1[j] = hit & pushFire;
        end
        isDup = hit;
        drop  = hit & (mkey <= push_key_i);
        if (drop) begin
            rm1 = '0;
        end
`endif

        for (int j = 0; j < DEPTH - 1; j++) begin
            k2[j] = rm1[j] ? k1[j+1] : k1[j];
            d2[j] = rm1[j] ? d1[j+1] : d1[j];
            v2[j] = rm1[j] ? v1[j+1] : v1[j];
        end
        k2[DEPTH-1] = rm1[DEPTH-1] ? '0   : k1[DEPTH-1];
        d2[DEPTH-1] = rm1[DEPTH-1] ? '0   : d1[DEPTH-1];
        v2[DEPTH-1] = rm1[DEPTH-1] ? 1'b0 : v1[DEPTH-1];

        doIns = pushFire & !drop;

        // Strict greater-than places a new entry behind equal keys; invalid slots always qualify.
        for (int j = 0; j < DEPTH; j++) begin
            ge[j] = !v2[j] || (k2[j] > push_key_i);
        end

        key_d   = k2;
        data_d  = d2;
        valid_d = v2;
        if (doIns) begin
            if (ge[0]) begin
                key_d[0]   = push_key_i;
                data_d[0]  = push_data_i;
                valid_d[0] = 1'b1;
            end
            for (int j = 1; j < DEPTH; j++) begin
                if (ge[j]) begin
                    key_d[j]   = ge[j-1] ? k2[j-1] : push_key_i;
                    data_d[j]  = ge[j-1] ? d2[j-1] : push_data_i;
                    valid_d[j] = ge[j-1] ? v2[j-1] : 1'b1;
                end
            end
        end

        count_d = count_q - CNT_W'(popFire) + CNT_W'(doIns & !isDup);

        if (clear_i) begin
            for (int j = 0; j < DEPTH; j++) begin
                key_d[j]  = '0;
                data_d[j] = '0;
            end
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < DEPTH; j++) begin
                key_q[j]  <= '0;
                data_q[j] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            key_q   <= key_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

`ifdef SORT_DEDUP_EN
    logic dropped_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= pushFire & drop & !clear_i;
        end
    end

    assign dropped_o = dropped_q;
`else
    assign dropped_o = 1'b0;
`endif

    assign head_valid_o = valid_q[0];
    assign head_key_o   = key_q[0];
    assign head_data_o  = data_q[0];
    assign count_o      = count_q;
    assign full_o       = (count_q == FULL_CNT);
    assign empty_o      = (count_q == '0);
    assign push_ready_o = !full_o;

endmodule

// File: doc/astar_open_pq.md
# astar_open_pq

Parametrised sorted priority queue for the A* open list, the next generation of the fixed `sort` block. It holds up to DEPTH (key, payload) entries in ascending key order and always presents the minimum-key entry at its head. Each cycle it accepts one push, one pop, or both. It sits between the neighbour-expansion logic (producer) and the node-selection FSM (consumer).

## Interface
- KEY_W, 16: width of the cost key (f = g + h), unsigned.
- DATA_W, 12: width of the payload (node index).
- DEPTH, 16: number of entries, ≥2.
- CNT_W, $clog2(DEPTH+1): width of count.
- Clk  in  1  single clock; all state on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; empties the queue next edge.
- push_valid  in  1  push request.
- push_key  in  KEY_W  key of pushed entry.
- push_data  in  DATA_W  payload of pushed entry.
- push_ready  out  1  high when a push will be accepted (= !full).
- pop  in  1  remove head entry this edge.
- head_valid  out  1  head_key/head_data are valid (= !empty).
- head_key  out  KEY_W  minimum key stored.
- head_data  out  DATA_W  payload of the minimum entry.
- count  out  CNT_W  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- dropped  out  1  one-cycle pulse: a push was discarded as a duplicate (SORT_DEDUP_EN only; tied 0 otherwise).

## Operation
- Storage is a register array e[0..DEPTH-1] of {key, data, valid}, kept sorted ascending by key. e[0] is the head. Valid entries are contiguous from index 0.
- Push fire = push_valid & push_ready. Pop fire = pop & head_valid. A pop while empty is ignored. A push while full is not accepted, and push_ready is low.
- Insert position is the first index i whose stored key > push_key. Entries at i and above shift up by one, and the new entry is written at i.
- Ties: the new entry is placed after all equal keys, so equal keys leave in FIFO order.
- Pop only: all entries shift down by one, and the top slot is invalidated.
- Push and pop in the same cycle: the head is removed, then the insert is computed on the remaining entries. count is unchanged. This is legal whenever not full.
- When full, push_ready is 0 even if pop is high. There is no combinational path from pop to push_ready.
- clear has priority over push and pop. It invalidates all entries, and count becomes 0.
- Arithmetic: keys compare as unsigned. count never exceeds DEPTH and never underflows.

## Timing
- Reset (Reset_n low, asynchronous) forces these values: all valid bits 0, count=0, empty=1, full=0, push_ready=1, head_valid=0, head_key=0, head_data=0, dropped=0.
- All outputs are driven straight from registers, or are decodes of count.
- Push latency: an accepted entry is reflected in count, and at the head if it is the minimum, after 1 edge.
- Pop latency: the next-smallest entry appears at the head 1 edge after the pop edge.
- Throughput is one operation (push, pop, or push+pop) per cycle, with no stalls.
- Reset_n asserted mid-operation aborts everything. Queue contents are lost, and no partial shift is visible.
- Invalid entries read key=0 and data=0, so head_key and head_data are 0 when empty.

## Configuration
- SORT_DEDUP_EN defined: a push whose push_data matches a valid stored payload is a decrease-key operation. All DEPTH payloads are compared in parallel.
  - If the stored key ≤ push_key, the push is consumed (push_ready unchanged), nothing is stored, and dropped pulses for 1 cycle.
  - Otherwise the old entry is removed and the new one is inserted by key in the same cycle. count is unchanged.
  - A duplicate push while full is still refused (push_ready=0).
  - With a simultaneous pop, the pop is applied first; if the pop removed the matching entry, the push is treated as a plain insert.
- SORT_DEDUP_EN undefined: duplicate payloads are stored as independent entries, and dropped is constant 0.

## Test plan
- Reset, then push keys 9,3,7,1 on consecutive cycles -> count=4; pops yield head_key 1,3,7,9 in order; empty=1 after the 4th pop.
- Push (5,A),(5,B),(5,C) -> pops yield data A,B,C (FIFO ties).
- Fill to DEPTH=16 -> full=1, push_ready=0; a push+pop cycle removes the head only and count becomes 15; pop on empty -> count stays 0.
- With 4 entries, assert push (key 2) and pop in the same cycle -> count stays 4 and the old head is gone; if 2 is below all remaining keys, head_key=2 next cycle.
- Assert Reset_n low mid-stream with 6 entries -> all outputs are at their reset values immediately; clear with 6 entries -> count=0 after 1 edge.
- SORT_DEDUP_EN: store (8,N5) and push (10,N5) -> dropped=1, count unchanged. Then push (2,N5) -> head=(2,N5), count unchanged, only one N5 present.
